// File: rtl/pll_reset_sequencer.sv
// Sequences the core PLL reset, supervises lock and releases core_reset_n after stable lock.
// Optional build macro PLL_RELOCK_CNT_EN adds the saturating relock_count output.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 1000000,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready
`ifdef PLL_RELOCK_CNT_EN
  ,
  output logic [7:0] relock_count
`endif
);

  localparam int RW = (RST_PULSE_CYC    > 1) ? $clog2(RST_PULSE_CYC)    : 1;
  localparam int SW = (LOCK_STABLE_CYC  > 1) ? $clog2(LOCK_STABLE_CYC)  : 1;
  localparam int TW = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_CYC - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [RW-1:0]          rst_cnt;
  logic [SW-1:0]          stb_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lk_s;

  assign lk_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RST_PLL: begin
        if (rst_cnt == RST_LAST) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (lk_s)                       state_nx = STABLE;
        else if (tmo_cnt == TMO_LAST)   state_nx = RST_PLL;
      end
      STABLE: begin
        if (!lk_s)                      state_nx = WAIT_LOCK;
        else if (stb_cnt == STB_LAST)   state_nx = RUN;
      end
      RUN: begin
        if (!lk_s) state_nx = RST_PLL;
      end
      default: state_nx = RST_PLL;
    endcase
  end

  // Counters run only while the state holds; any transition clears them.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RST_PLL;
      rst_cnt      <= '0;
      stb_cnt      <= '0;
      tmo_cnt      <= '0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      pll_ready    <= 1'b0;
    end else begin
      state        <= state_nx;
      rst_cnt      <= (state == RST_PLL   && state_nx == RST_PLL)   ? rst_cnt + 1'b1 : '0;
      tmo_cnt      <= (state == WAIT_LOCK && state_nx == WAIT_LOCK) ? tmo_cnt + 1'b1 : '0;
      stb_cnt      <= (state == STABLE    && state_nx == STABLE)    ? stb_cnt + 1'b1 : '0;
      pll_rst      <= (state_nx == RST_PLL);
      core_reset_n <= (state_nx == RUN);
      pll_ready    <= (state_nx == RUN);
    end
  end

`ifdef PLL_RELOCK_CNT_EN
  logic relock_evt;

  assign relock_evt = (state == WAIT_LOCK && !lk_s && tmo_cnt == TMO_LAST) ||
                      (state == RUN && !lk_s);

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      relock_count <= 8'd0;
    end else if (relock_evt && relock_count != 8'hFF) begin
      relock_count <= relock_count + 8'd1;
    end
  end
`endif

endmodule
